mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port (memadr/memdata/membyteen/memrwb/memen/memdone) among three requesters: instruction-cache refill, data-cache refill and the write buffer.
- Refills are LINE_WORDS-beat read bursts with the low address bits sequenced internally. Write-buffer drains are single-word writes.
- Sits between the cache controller and mainmem. Exactly one memory transaction is outstanding at a time.

Parameters:
ADR_W, 27, memory word-address width
LINE_WORDS, 4, words per cache-line refill burst (power of 2)
BEAT_W, 2, log2(LINE_WORDS)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset)
ireq  input  1  icache refill request; level, held until idone
iadr  input  ADR_W  icache line address; low BEAT_W bits ignored
ivalid  output  1  one-cycle pulse per returned icache word
idone  output  1  one-cycle pulse with last icache beat
dreq  input  1  dcache refill request; level, held until ddone
dadr  input  ADR_W  dcache line address; low BEAT_W bits ignored
dvalid  output  1  one-cycle pulse per returned dcache word
ddone  output  1  one-cycle pulse with last dcache beat
rdata  output  32  registered read word, valid with ivalid/dvalid
beat  output  BEAT_W  index of the word in rdata
wreq  input  1  write-buffer request; level, held until wdone
wadr  input  ADR_W  write word address
wdata  input  32  write data
wbyteen  input  4  write byte enables
wdone  output  1  one-cycle pulse when the write completes
memadr  output  ADR_W  memory address
memwdata  output  32  memory write data; top level drives the bidirectional memdata from it
memrdata  input  32  memory read data
membyteen  output  4  memory byte enables; 4'b1111 on reads
memrwb  output  1  1 = read, 0 = write
memen  output  1  memory access enable
memdone  input  1  memory access-complete strobe

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, beat counter=0. All outputs 0 except memrwb=1. Any in-flight access is abandoned; memen drops at that edge. Requesters keep or re-assert their req.
- States:
  - IDLE: sample requests. If any is pending, latch the winner plus its address/data/byteen and go to ACCESS. Decision to memen high = 1 cycle.
  - ACCESS: memen=1; memadr = latched line base with beat counter in the low BEAT_W bits (the latched word address for writes). Outputs are held stable until memdone=1 is sampled. On that edge:
    - Read: rdata<=memrdata, beat<=counter, and the owner's valid pulses.
    - Last beat (the write, or counter==LINE_WORDS-1): the owner's done pulses and the next state is IDLE.
    - Otherwise: counter++ and the next state is GAP.
  - GAP: memen=0 for exactly one cycle, then ACCESS. The burst is never preempted.
- Fixed priority: write buffer > dcache > icache. The write buffer must drain before a refill, so a refill never reads stale memory.
- Simultaneous events:
  - A request and another requester's done in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - The owner dropping req mid-burst is ignored; the burst completes.
- memdone while in IDLE/GAP is ignored.
- Minimum refill = LINE_WORDS*2 cycles with zero-wait memory. Minimum write = 2 cycles.
- Address wrap: the beat counter wraps within the line and never carries into bit BEAT_W.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: icache and dcache alternate via a last-served-refill flag (round robin). The flag resets to "icache served", so dcache wins the first tie. The write buffer keeps top priority only when wadr's line matches a pending refill line or both refills are idle. Otherwise a refill may bypass up to one pending write.
- Undefined: fixed priority as above.

Decomposition:
- Shared package mem_pkg holds:
  - the owner enum (OWN_NONE/OWN_I/OWN_D/OWN_W)
  - the state enum (IDLE/ACCESS/GAP)
  - default ADR_W and LINE_WORDS constants
- Sub-module mem_arb_pick: combinational winner selection from reqs, the RR flag and the line-match input, so the policy is swappable.
- Sequencer FSM and burst counter stay in mem_arbiter.

Test Plan:
- Lone icache refill: ireq=1, iadr=27'h04AD, memdone tied 1 -> memadr 04AC,04AD,04AE,04AF with a memen gap between beats; four ivalid pulses with beat 0..3; idone on beat 3; total 8 cycles.
- Simultaneous wreq (wadr=27'h0000, wdata=DEADBEEF, wbyteen=4'b1011) and dreq (dadr=0) -> write first: memrwb=0, membyteen=1011, wdone. Then the dcache burst reads back DEADBEEF at beat 0.
- Wait states: memdone held 0 for 5 cycles per beat -> memadr/memen stable throughout; no valid until memdone; no extra beats.
- Reset asserted mid-burst (after beat 1) -> next edge memen=0, all pulses 0; after release with ireq still 1, the burst restarts at beat 0.
- MEM_ARB_RR_EN: ireq and dreq held continuously -> grants alternate D,I,D,I. Without the macro: all D until dreq drops.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory arbiter.
package mem_pkg;
    localparam int MEM_ADR_W      = 27;
    localparam int MEM_LINE_WORDS = 4;

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_W} owner_t;
    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin refills with a bounded write bypass; otherwise W > D > I.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic   ireq,
    input  logic   dreq,
    input  logic   wreq,
    input  logic   last_d,
    input  logic   line_match,
    input  logic   w_bypassed,
    output owner_t win
);

    always_comb begin
        win = OWN_NONE;
`ifdef MEM_ARB_RR_EN
        // A write goes first if it could alias a refill line, already lost once, or is alone.
        if (wreq && (line_match || w_bypassed || !(ireq || dreq))) win = OWN_W;
        else if (ireq && dreq)                                      win = last_d ? OWN_I : OWN_D;
        else if (dreq)                                              win = OWN_D;
        else if (ireq)                                              win = OWN_I;
`else
        if (wreq)      win = OWN_W;
        else if (dreq) win = OWN_D;
        else if (ireq) win = OWN_I;
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic unused_rr;
    assign unused_rr = ^{last_d, line_match, w_bypassed};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between icache refill, dcache refill and the write buffer.
// Optional MEM_ARB_RR_EN: round-robin between refills (see mem_arb_pick).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADR_W      = MEM_ADR_W,
    parameter int LINE_WORDS = MEM_LINE_WORDS,
    parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq,
    input  logic [ADR_W-1:0]  iadr,
    output logic              ivalid,
    output logic              idone,
    input  logic              dreq,
    input  logic [ADR_W-1:0]  dadr,
    output logic              dvalid,
    output logic              ddone,
    output logic [31:0]       rdata,
    output logic [BEAT_W-1:0] beat,
    input  logic              wreq,
    input  logic [ADR_W-1:0]  wadr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wbyteen,
    output logic              wdone,
    output logic [ADR_W-1:0]  memadr,
    output logic [31:0]       memwdata,
    input  logic [31:0]       memrdata,
    output logic [3:0]        membyteen,
    output logic              memrwb,
    output logic              memen,
    input  logic              memdone
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_t            state;
    owner_t            owner;
    owner_t            win;
    logic [ADR_W-1:0]  adr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        byteen_q;
    logic [BEAT_W-1:0] cnt;
    logic              last_d;
    logic              w_byp;
    logic              line_match;
    logic              grant;

    assign grant = (state == IDLE) && (win != OWN_NONE);

`ifdef MEM_ARB_RR_EN
    assign line_match = wreq &&
        ((ireq && wadr[ADR_W-1:BEAT_W] == iadr[ADR_W-1:BEAT_W]) ||
         (dreq && wadr[ADR_W-1:BEAT_W] == dadr[ADR_W-1:BEAT_W]));

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_d <= 1'b0;
            w_byp  <= 1'b0;
        end else if (grant) begin
            if (win == OWN_W) begin
                w_byp <= 1'b0;
            end else begin
                last_d <= (win == OWN_D);
                w_byp  <= wreq;
            end
        end
    end
`else
    assign line_match = 1'b0;
    assign last_d     = 1'b0;
    assign w_byp      = 1'b0;
`endif

    mem_arb_pick u_pick (
        .ireq       (ireq),
        .dreq       (dreq),
        .wreq       (wreq),
        .last_d     (last_d),
        .line_match (line_match),
        .w_bypassed (w_byp),
        .win        (win)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            adr_q    <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            cnt      <= '0;
            rdata    <= '0;
            beat     <= '0;
            ivalid   <= 1'b0;
            idone    <= 1'b0;
            dvalid   <= 1'b0;
            ddone    <= 1'b0;
            wdone    <= 1'b0;
        end else begin
            ivalid <= 1'b0;
            idone  <= 1'b0;
            dvalid <= 1'b0;
            ddone  <= 1'b0;
            wdone  <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    owner <= win;
                    state <= ACCESS;
                    cnt   <= '0;
                    case (win)
                        OWN_W: begin
                            adr_q    <= wadr;
                            wdata_q  <= wdata;
                            byteen_q <= wbyteen;
                        end
                        OWN_D:   adr_q <= dadr;
                        default: adr_q <= iadr;
                    endcase
                end
                ACCESS: if (memdone) begin
                    if (owner != OWN_W) begin
                        rdata  <= memrdata;
                        beat   <= cnt;
                        ivalid <= (owner == OWN_I);
                        dvalid <= (owner == OWN_D);
                    end
                    if (owner == OWN_W || cnt == LAST_BEAT) begin
                        idone <= (owner == OWN_I);
                        ddone <= (owner == OWN_D);
                        wdone <= (owner == OWN_W);
                        owner <= OWN_NONE;
                        state <= IDLE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= GAP;
                    end
                end
                GAP:     state <= ACCESS;
                default: state <= IDLE;
            endcase
        end
    end

    // Refills walk the line from its base; the counter wraps inside the line.
    assign memadr    = (owner == OWN_W) ? adr_q : {adr_q[ADR_W-1:BEAT_W], cnt};
    assign memwdata  = wdata_q;
    assign membyteen = (owner == OWN_W) ? byteen_q : ((owner == OWN_NONE) ? 4'h0 : 4'hF);
    assign memrwb    = (owner != OWN_W);
    assign memen     = (state == ACCESS);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small byte-enabled memory model.
module tb_mem_arbiter;
    localparam int ADR_W = 27;
    localparam int BEAT_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ireq = 1'b0, dreq = 1'b0, wreq = 1'b0;
    logic [ADR_W-1:0]  iadr = '0, dadr = '0, wadr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wbyteen = '0;
    logic              ivalid, idone, dvalid, ddone, wdone;
    logic [31:0]       rdata;
    logic [BEAT_W-1:0] beat;
    logic [ADR_W-1:0]  memadr;
    logic [31:0]       memwdata, memrdata;
    logic [3:0]        membyteen;
    logic              memrwb, memen, memdone;

    logic              wait_mode = 1'b0;
    int                wcnt = 0;
    int                n_chk = 0;
    int                n_fail = 0;

    logic [31:0] mem [64];
    bit          wrf [64];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iadr(iadr), .ivalid(ivalid), .idone(idone),
        .dreq(dreq), .dadr(dadr), .dvalid(dvalid), .ddone(ddone),
        .rdata(rdata), .beat(beat),
        .wreq(wreq), .wadr(wadr), .wdata(wdata), .wbyteen(wbyteen), .wdone(wdone),
        .memadr(memadr), .memwdata(memwdata), .memrdata(memrdata),
        .membyteen(membyteen), .memrwb(memrwb), .memen(memen), .memdone(memdone)
    );

    // Unwritten words read as 11AD22xx with xx = word index.
    function automatic logic [31:0] cur(input logic [5:0] i);
        return wrf[i] ? mem[i] : (32'h11AD2200 | {26'd0, i});
    endfunction

    always_comb memrdata = cur(memadr[5:0]);
    assign memdone = wait_mode ? (memen && wcnt == 5) : 1'b1;

    always @(posedge clk) begin
        logic [31:0] v;
        wcnt <= memen ? wcnt + 1 : 0;
        if (memen && memdone && !memrwb) begin
            v = cur(memadr[5:0]);
            for (int b = 0; b < 4; b++)
                if (membyteen[b]) v[8*b +: 8] = memwdata[8*b +: 8];
            mem[memadr[5:0]] <= v;
            wrf[memadr[5:0]] <= 1'b1;
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({memen, memrwb, ivalid, idone, dvalid, ddone, wdone} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 0100000", {memen, memrwb, ivalid, idone, dvalid, ddone, wdone});
        end
        n_chk++;
        if (memadr !== '0 || membyteen !== 4'h0 || rdata !== 32'h0 || beat !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: got adr=%h be=%h rdata=%h beat=%0d expected all zero", memadr, membyteen, rdata, beat);
        end
        reset = 1'b1;
    endtask

    task automatic test_icache();
        iadr = 27'h04AD;
        ireq = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if ({memen, ivalid, idone, dvalid} !== {c % 2 == 0, c % 2 == 1, c == 7, 1'b0}) begin
                n_fail++;
                $display("FAIL icache_ctl[%0d]: got %b", c, {memen, ivalid, idone, dvalid});
            end
            n_chk++;
            if (c % 2 == 0) begin
                if (memadr !== 27'h04AC + 27'(c / 2) || memrwb !== 1'b1 || membyteen !== 4'hF) begin
                    n_fail++;
                    $display("FAIL icache_adr[%0d]: got %h rwb=%b be=%h expected %h", c, memadr, memrwb, membyteen, 27'h04AC + 27'(c / 2));
                end
            end else if (beat !== 2'(c / 2) || rdata !== 32'h11AD222C + 32'(c / 2)) begin
                n_fail++;
                $display("FAIL icache_data[%0d]: got beat=%0d rdata=%h", c, beat, rdata);
            end
        end
        ireq = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (memen !== 1'b0 || ivalid !== 1'b0) begin
            n_fail++;
            $display("FAIL icache_idle: got memen=%b ivalid=%b expected 0 0", memen, ivalid);
        end
    endtask

    task automatic test_write_first();
        wadr = '0; wdata = 32'hDEADBEEF; wbyteen = 4'b1011; wreq = 1'b1;
        dadr = '0; dreq = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({memen, memrwb} !== 2'b10 || membyteen !== 4'b1011 || memadr !== '0 || memwdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_req: got en=%b rwb=%b be=%b adr=%h wd=%h", memen, memrwb, membyteen, memadr, memwdata);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({wdone, memen, dvalid} !== 3'b100) begin
            n_fail++;
            $display("FAIL write_done: got %b expected 100", {wdone, memen, dvalid});
        end
        wreq = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({memen, memrwb} !== 2'b11 || membyteen !== 4'hF || memadr !== '0) begin
            n_fail++;
            $display("FAIL dref_req: got en=%b rwb=%b be=%h adr=%h", memen, memrwb, membyteen, memadr);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (dvalid !== 1'b1 || beat !== 2'd0 || rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL dref_beat0: got v=%b beat=%0d rdata=%h expected 1 0 deadbeef", dvalid, beat, rdata);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if ({ddone, dvalid} !== {k == 5, k % 2 == 1}) begin
                n_fail++;
                $display("FAIL dref_tail[%0d]: got done=%b valid=%b", k, ddone, dvalid);
            end
        end
        n_chk++;
        if (rdata !== 32'h11AD2203 || beat !== 2'd3) begin
            n_fail++;
            $display("FAIL dref_last: got %h beat=%0d expected 11ad2203 3", rdata, beat);
        end
        dreq = 1'b0;
    endtask

    task automatic test_wait();
        wait_mode = 1'b1;
        iadr = 27'h0010;
        ireq = 1'b1;
        for (int c = 0; c < 28; c++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if ({memen, ivalid, idone} !== {c % 7 != 6, c % 7 == 6, c == 27}) begin
                n_fail++;
                $display("FAIL wait_ctl[%0d]: got %b", c, {memen, ivalid, idone});
            end
            if (c % 7 != 6) begin
                n_chk++;
                if (memadr !== 27'h0010 + 27'(c / 7)) begin
                    n_fail++;
                    $display("FAIL wait_adr[%0d]: got %h expected %h", c, memadr, 27'h0010 + 27'(c / 7));
                end
            end
        end
        ireq = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if ({memen, ivalid, idone} !== 3'b000) begin
                n_fail++;
                $display("FAIL wait_extra[%0d]: got %b expected 000", c, {memen, ivalid, idone});
            end
        end
        wait_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        iadr = 27'h0020;
        ireq = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_chk++;
        if (ivalid !== 1'b1 || beat !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_pre: got valid=%b beat=%0d expected 1 1", ivalid, beat);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({memen, memrwb, ivalid, idone} !== 4'b0100 || memadr !== '0) begin
            n_fail++;
            $display("FAIL rmid_reset: got %b adr=%h expected 0100 0", {memen, memrwb, ivalid, idone}, memadr);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (memen !== 1'b1 || memadr !== 27'h0020) begin
            n_fail++;
            $display("FAIL rmid_restart: got en=%b adr=%h expected 1 0000020", memen, memadr);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (ivalid !== 1'b1 || beat !== 2'd0 || rdata !== 32'h11AD2220) begin
            n_fail++;
            $display("FAIL rmid_beat0: got v=%b beat=%0d rdata=%h", ivalid, beat, rdata);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (idone !== (k == 5)) begin
                n_fail++;
                $display("FAIL rmid_done[%0d]: got %b", k, idone);
            end
        end
        ireq = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arb();
        logic [1:0] exp;
        bit got;
        iadr = 27'h0030; dadr = 27'h0034;
        ireq = 1'b1; dreq = 1'b1;
        for (int n = 0; n < 5; n++) begin
`ifdef MEM_ARB_RR_EN
            exp = (n % 2 == 0 && n < 4) ? 2'b01 : 2'b10;
`else
            exp = (n < 4) ? 2'b01 : 2'b10;
`endif
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(posedge clk);
                #1;
                if (idone || ddone) got = 1'b1;
            end
            n_chk++;
            if (!got) begin
                n_fail++;
                $display("FAIL arb_grant[%0d]: no done within 20 cycles", n);
            end else if ({idone, ddone} !== exp) begin
                n_fail++;
                $display("FAIL arb_grant[%0d]: got {idone,ddone}=%b expected %b", n, {idone, ddone}, exp);
            end
            if (n == 3) dreq = 1'b0;
        end
        ireq = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_icache();
        test_write_first();
        test_wait();
        test_reset_mid();
        test_arb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
